fifo_port: RTL and testbench

FIFO_PORT -- requirements
Module: fifo_port

---
 rtl/fifo_port_pkg.sv | 30 +++
 rtl/fifo_port_fifo_sync.sv | 60 ++++++
 rtl/fifo_port.sv | 150 +++++++++++++++
 tb/tb_fifo_port.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_port_pkg.sv
// fifo_port_pkg
//   Shared bus constants for the SPI-gate byte port: default port addresses,
//   status-byte bit positions, the bus-enable state type and a helper that
//   saturates a FIFO level into the 4-bit status field.
package fifo_port_pkg;

  // Default port addresses seen on ADDR from the SPI gate.
  localparam logic [7:0] DEF_WR_ADDR   = 8'h10;
  localparam logic [7:0] DEF_RD_ADDR   = 8'h11;
  localparam logic [7:0] DEF_STAT_ADDR = 8'h12;

  // Status byte layout: {0, TX_UNF, RX_OVF, rx_full, tx_level[3:0]}.
  localparam int ST_BIT_TX_UNF  = 6;
  localparam int ST_BIT_RX_OVF  = 5;
  localparam int ST_BIT_RX_FULL = 4;
  localparam int ST_LVL_MSB     = 3;

  // Bus-side enable: after reset the port ignores the gate until it has
  // seen SEL low once, so a half-finished transaction cannot leak in.
  typedef enum logic {
    ST_WAIT_IDLE = 1'b0,
    ST_LIVE      = 1'b1
  } bus_state_e;

  // Clamp a FIFO level to the 4-bit status field.
  function automatic logic [3:0] sat_level(input logic [7:0] lvl);
    return (lvl > 8'd15) ? 4'hF : lvl[3:0];
  endfunction

endpackage

// File: rtl/fifo_port_fifo_sync.sv
// fifo_sync
//   Single-clock FIFO with (DEPTH_LOG2+1)-bit wrapping pointers.
//   Ports:
//     CLK, nRST        clock, asynchronous active-low reset
//     push, push_data  write request (ignored when full)
//     pop              read request (ignored when empty)
//     head             oldest entry, 0 while empty
//     full, empty      occupancy flags
//     level            entry count, wr_ptr - rd_ptr
module fifo_sync #(
  parameter int DEPTH_LOG2 = 4,
  parameter int W          = 8
) (
  input  logic                  CLK,
  input  logic                  nRST,
  input  logic                  push,
  input  logic [W-1:0]          push_data,
  input  logic                  pop,
  output logic [W-1:0]          head,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   level
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] PTR_ONE = {{DEPTH_LOG2{1'b0}}, 1'b1};

  logic [DEPTH_LOG2:0] wr_ptr;
  logic [DEPTH_LOG2:0] rd_ptr;
  logic [W-1:0]        mem [DEPTH];
  logic                do_push;
  logic                do_pop;

  // The extra pointer MSB tells a full FIFO from an empty one.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[DEPTH_LOG2] != rd_ptr[DEPTH_LOG2]) &&
                   (wr_ptr[DEPTH_LOG2-1:0] == rd_ptr[DEPTH_LOG2-1:0]);
  assign level   = wr_ptr - rd_ptr;
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Masking keeps stale storage invisible after reset.
  assign head = empty ? '0 : mem[rd_ptr[DEPTH_LOG2-1:0]];

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // Storage carries no reset; occupancy is defined by the pointers alone.
  always_ff @(posedge CLK) begin
    if (do_push) mem[wr_ptr[DEPTH_LOG2-1:0]] <= push_data;
  end

endmodule

// File: rtl/fifo_port.sv
// fifo_port
//   Byte port between an SPI gate (host side) and user logic. Host writes to
//   WR_ADDR fill the RX FIFO, host reads of RD_ADDR drain the TX FIFO, and
//   STAT_ADDR returns/clears the status byte.
//   Ports:
//     CLK, nRST                 clock, asynchronous active-low reset
//     RXD, ADDR, SEL, TXE, RXE  SPI gate side; TXD is high-Z unless driven
//     RX_DATA/RX_VALID/RX_READY user RX stream (RX FIFO head)
//     TX_DATA/TX_VALID/TX_READY user TX stream (TX FIFO tail)
//     dbg_state                 bus-enable state for observation
//   Handshake: a transfer happens on a rising CLK edge exactly when VALID and
//   READY are both high; VALID never depends on READY, and data is held
//   stable by the source while VALID is high and READY is low.
module fifo_port
  import fifo_port_pkg::*;
#(
  parameter logic [7:0] WR_ADDR    = DEF_WR_ADDR,
  parameter logic [7:0] RD_ADDR    = DEF_RD_ADDR,
  parameter logic [7:0] STAT_ADDR  = DEF_STAT_ADDR,
  parameter int         DEPTH_LOG2 = 4
) (
  input  logic       CLK,
  input  logic       nRST,
  input  logic [7:0] RXD,
  output logic [7:0] TXD,
  input  logic [7:0] ADDR,
  input  logic       SEL,
  input  logic       TXE,
  input  logic       RXE,
  output logic [7:0] RX_DATA,
  output logic       RX_VALID,
  input  logic       RX_READY,
  input  logic [7:0] TX_DATA,
  input  logic       TX_VALID,
  output logic       TX_READY,
  output bus_state_e dbg_state
);

  bus_state_e state_q;
  bus_state_e state_d;

  logic bus_en;
  logic wr_hit, rd_hit, st_hit;

  logic                rx_push, rx_pop, rx_full, rx_empty;
  logic [DEPTH_LOG2:0] rx_level;
  logic                tx_push, tx_pop, tx_full, tx_empty;
  logic [DEPTH_LOG2:0] tx_level;
  logic [7:0]          tx_head;

  logic rx_ovf_q, tx_unf_q, loaded_q;
  logic rx_ovf_set, tx_unf_set, flag_clr;

  logic       txd_oe;
  logic [7:0] txd_val;
  logic [7:0] status;

  // Bus-enable FSM.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) state_q <= ST_WAIT_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_WAIT_IDLE: if (!SEL) state_d = ST_LIVE;
      ST_LIVE:      state_d = ST_LIVE;
      default:      state_d = ST_WAIT_IDLE;
    endcase
  end

  assign dbg_state = state_q;
  assign bus_en    = (state_q == ST_LIVE);

  assign wr_hit = (ADDR == WR_ADDR);
  assign rd_hit = (ADDR == RD_ADDR);
  assign st_hit = (ADDR == STAT_ADDR);

  // RX path: a write into a full FIFO is dropped even if the user pops in
  // the same cycle, because fullness is judged before the pop.
  assign rx_push    = bus_en && RXE && wr_hit && !rx_full;
  assign rx_ovf_set = bus_en && RXE && wr_hit && rx_full;
  assign rx_pop     = RX_VALID && RX_READY;

  // TX path: a bus pop only consumes a byte that was actually presented
  // (LOADED); otherwise the host clocked out the 8'h00 filler.
  assign tx_push    = TX_VALID && TX_READY;
  assign tx_pop     = bus_en && RXE && rd_hit && loaded_q;
  assign tx_unf_set = bus_en && RXE && rd_hit && !loaded_q;
  assign flag_clr   = bus_en && RXE && st_hit;

  fifo_sync #(.DEPTH_LOG2(DEPTH_LOG2), .W(8)) u_rx_fifo (
    .CLK       (CLK),
    .nRST      (nRST),
    .push      (rx_push),
    .push_data (RXD),
    .pop       (rx_pop),
    .head      (RX_DATA),
    .full      (rx_full),
    .empty     (rx_empty),
    .level     (rx_level)
  );

  fifo_sync #(.DEPTH_LOG2(DEPTH_LOG2), .W(8)) u_tx_fifo (
    .CLK       (CLK),
    .nRST      (nRST),
    .push      (tx_push),
    .push_data (TX_DATA),
    .pop       (tx_pop),
    .head      (tx_head),
    .full      (tx_full),
    .empty     (tx_empty),
    .level     (tx_level)
  );

  assign RX_VALID = !rx_empty;
  assign TX_READY = !tx_full;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      rx_ovf_q <= 1'b0;
      tx_unf_q <= 1'b0;
      loaded_q <= 1'b0;
    end else begin
      // A clear and a new event in the same cycle leave the flag set.
      rx_ovf_q <= (rx_ovf_q && !flag_clr) || rx_ovf_set;
      tx_unf_q <= (tx_unf_q && !flag_clr) || tx_unf_set;
      // A prefetched byte not followed by RXE before SEL falls stays queued.
      if (!SEL)
        loaded_q <= 1'b0;
      else if (bus_en && TXE && rd_hit)
        loaded_q <= !tx_empty;
    end
  end

  // The RX FIFO is at its limit exactly when the level MSB is set.
  always_comb begin
    status                   = 8'h00;
    status[ST_BIT_TX_UNF]    = tx_unf_q;
    status[ST_BIT_RX_OVF]    = rx_ovf_q;
    status[ST_BIT_RX_FULL]   = rx_level[DEPTH_LOG2];
    status[ST_LVL_MSB:0]     = sat_level(8'(tx_level));
  end

  assign txd_oe  = bus_en && TXE && (rd_hit || st_hit);
  assign txd_val = st_hit ? status : tx_head;
  assign TXD     = txd_oe ? txd_val : 8'hzz;

endmodule

// File: tb/tb_fifo_port.sv
module tb_fifo_port;
  import fifo_port_pkg::*;

  localparam logic [7:0] WR_A   = 8'h10;
  localparam logic [7:0] RD_A   = 8'h11;
  localparam logic [7:0] STAT_A = 8'h12;
  localparam int         DEPTH  = 16;

  // ---------------- clock / reset / DUT ----------------
  logic       CLK = 1'b0;
  logic       nRST;
  logic [7:0] RXD, ADDR, TX_DATA;
  logic       SEL, TXE, RXE, RX_READY, TX_VALID;
  wire  [7:0] TXD;
  logic [7:0] RX_DATA;
  logic       RX_VALID, TX_READY;
  bus_state_e dbg_state;

  always #5 CLK = ~CLK;

  fifo_port dut (
    .CLK       (CLK),
    .nRST      (nRST),
    .RXD       (RXD),
    .TXD       (TXD),
    .ADDR      (ADDR),
    .SEL       (SEL),
    .TXE       (TXE),
    .RXE       (RXE),
    .RX_DATA   (RX_DATA),
    .RX_VALID  (RX_VALID),
    .RX_READY  (RX_READY),
    .TX_DATA   (TX_DATA),
    .TX_VALID  (TX_VALID),
    .TX_READY  (TX_READY),
    .dbg_state (dbg_state)
  );

  // ---------------- reference model ----------------
  logic [7:0] rx_q[$];
  logic [7:0] tx_q[$];
  logic [7:0] rx_got[$];
  logic       ovf_m, unf_m, loaded_m, live;
  logic [7:0] last_txd;

  int n_cmp = 0;
  int n_bad = 0;

  function automatic logic [7:0] status_model();
    int lvl;
    lvl = (tx_q.size() > 15) ? 15 : tx_q.size();
    return {1'b0, unf_m, ovf_m, (rx_q.size() == DEPTH), 4'(lvl)};
  endfunction

  task automatic model_reset();
    rx_q.delete();
    tx_q.delete();
    ovf_m = 1'b0; unf_m = 1'b0; loaded_m = 1'b0; live = 1'b0;
  endtask

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
    end
  endtask

  // ---------------- driver: one clock cycle ----------------
  // Called at a falling edge with inputs already set.
  task automatic step();
    int         rx_n, tx_n;
    logic       drive_exp, push_rx, pop_tx, push_tx, tx_empty_pre;
    logic [7:0] txd_exp;
    #1;
    rx_n = rx_q.size();
    tx_n = tx_q.size();
    tx_empty_pre = (tx_n == 0);
    drive_exp = live && TXE && (ADDR == RD_A || ADDR == STAT_A);
    chk1("txd_oe", dut.txd_oe, drive_exp);
    if (drive_exp) begin
      if (ADDR == RD_A) txd_exp = (tx_n > 0) ? tx_q[0] : 8'h00;
      else              txd_exp = status_model();
      chk8("txd", TXD, txd_exp);
      last_txd = TXD;
    end
    if (RX_READY && rx_n > 0) rx_got.push_back(RX_DATA);

    // Flag clear first so an event in the same cycle wins.
    if (live && RXE && ADDR == STAT_A) begin
      ovf_m = 1'b0; unf_m = 1'b0;
    end
    push_rx = 1'b0;
    if (live && RXE && ADDR == WR_A) begin
      if (rx_n == DEPTH) ovf_m = 1'b1;
      else               push_rx = 1'b1;
    end
    if (RX_READY && rx_n > 0) void'(rx_q.pop_front());
    if (push_rx) rx_q.push_back(RXD);

    pop_tx = live && RXE && ADDR == RD_A && loaded_m;
    if (live && RXE && ADDR == RD_A && !loaded_m) unf_m = 1'b1;
    push_tx = TX_VALID && tx_n < DEPTH;
    if (pop_tx)  void'(tx_q.pop_front());
    if (push_tx) tx_q.push_back(TX_DATA);

    if (!SEL) loaded_m = 1'b0;
    else if (live && TXE && ADDR == RD_A) loaded_m = !tx_empty_pre;
    if (!SEL) live = 1'b1;

    @(posedge CLK);
    @(negedge CLK);
    chk1("rx_valid", RX_VALID, rx_q.size() > 0);
    chk1("tx_ready", TX_READY, tx_q.size() < DEPTH);
    chk1("dbg_live", dbg_state == ST_LIVE, live);
    if (rx_q.size() > 0) chk8("rx_data", RX_DATA, rx_q[0]);
  endtask

  task automatic host_write(input logic [7:0] b);
    SEL = 1'b1; ADDR = WR_A; RXD = b; TXE = 1'b0; RXE = 1'b1;
    step();
    RXE = 1'b0;
    step();
  endtask

  task automatic host_read(input logic [7:0] a, output logic [7:0] got);
    last_txd = 8'hEE;
    SEL = 1'b1; ADDR = a; RXE = 1'b0; TXE = 1'b1;
    step();
    step();
    got = last_txd;
    TXE = 1'b0; RXE = 1'b1;
    step();
    RXE = 1'b0;
    step();
  endtask

  // Two TXE cycles with no RXE: prefetch only.
  task automatic host_peek();
    SEL = 1'b1; ADDR = RD_A; RXE = 1'b0; TXE = 1'b1;
    step();
    step();
    TXE = 1'b0;
  endtask

  task automatic deselect();
    SEL = 1'b0; TXE = 1'b0; RXE = 1'b0;
    step();
  endtask

  task automatic user_push(input logic [7:0] b);
    TX_VALID = 1'b1; TX_DATA = b;
    step();
    TX_VALID = 1'b0;
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #300000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "watchdog expired");
  end

  // ---------------- directed + random sequence ----------------
  initial begin
    logic [7:0] got;
    logic [7:0] wr_bytes[$];
    int         op;

    nRST = 1'b0; RXD = '0; ADDR = STAT_A; TX_DATA = '0;
    SEL = 1'b1; TXE = 1'b1; RXE = 1'b0; RX_READY = 1'b0; TX_VALID = 1'b0;
    model_reset();
    last_txd = 8'hEE;
    repeat (3) @(negedge CLK);
    #1;
    chk1("reset_rx_valid", RX_VALID, 1'b0);
    chk1("reset_tx_ready", TX_READY, 1'b1);
    chk8("reset_rx_data", RX_DATA, 8'h00);
    chk1("reset_txd_oe", dut.txd_oe, 1'b0);
    SEL = 1'b0; TXE = 1'b0; ADDR = '0;
    @(negedge CLK);
    nRST = 1'b1;
    deselect();

    // Three host writes drained with RX_READY held high.
    RX_READY = 1'b1;
    rx_got.delete();
    host_write(8'hA1); host_write(8'hB2); host_write(8'hC3);
    deselect();
    chk8("w3_count", 8'(rx_got.size()), 8'd3);
    chk8("w3_b0", rx_got[0], 8'hA1);
    chk8("w3_b1", rx_got[1], 8'hB2);
    chk8("w3_b2", rx_got[2], 8'hC3);
    chk1("w3_rx_valid_low", RX_VALID, 1'b0);

    // Two user pushes, two host reads.
    user_push(8'h55); user_push(8'h66);
    host_read(RD_A, got); chk8("r2_b0", got, 8'h55);
    host_read(RD_A, got); chk8("r2_b1", got, 8'h66);
    deselect();
    host_read(STAT_A, got); chk8("r2_status", got, 8'h00);
    deselect();

    // Three pushes, two reads: the third byte survives the prefetch.
    user_push(8'h55); user_push(8'h66); user_push(8'h77);
    host_read(RD_A, got); chk8("r3_b0", got, 8'h55);
    host_read(RD_A, got); chk8("r3_b1", got, 8'h66);
    host_peek();
    deselect();
    host_read(STAT_A, got); chk8("r3_level", {4'h0, got[3:0]}, 8'h01);
    deselect();
    host_read(RD_A, got); chk8("r3_b2", got, 8'h77);
    deselect();

    // Underflow: empty read returns filler, status read clears the flag.
    host_read(RD_A, got); chk8("unf_filler", got, 8'h00);
    deselect();
    host_read(STAT_A, got); chk1("unf_set", got[6], 1'b1);
    deselect();
    host_read(STAT_A, got); chk1("unf_cleared", got[6], 1'b0);
    deselect();

    // Overflow: 17 writes with no user pops keep the first 16.
    RX_READY = 1'b0;
    wr_bytes.delete();
    for (int i = 0; i < 17; i++) begin
      wr_bytes.push_back(8'($urandom_range(0, 255)));
      host_write(wr_bytes[i]);
    end
    host_read(STAT_A, got);
    chk1("ovf_rx_full", got[4], 1'b1);
    chk1("ovf_flag", got[5], 1'b1);
    deselect();
    rx_got.delete();
    RX_READY = 1'b1;
    repeat (18) step();
    chk8("ovf_kept", 8'(rx_got.size()), 8'd16);
    for (int i = 0; i < 16; i++) chk8("ovf_byte", rx_got[i], wr_bytes[i]);
    host_read(STAT_A, got);
    deselect();

    // Randomised traffic against the model.
    for (int n = 0; n < 170; n++) begin
      RX_READY = 1'($urandom_range(0, 1));
      TX_VALID = 1'($urandom_range(0, 1));
      TX_DATA  = 8'($urandom_range(0, 255));
      op = $urandom_range(0, 6);
      case (op)
        0: user_push(8'($urandom_range(0, 255)));
        1: host_write(8'($urandom_range(0, 255)));
        2: host_read(RD_A, got);
        3: host_read(STAT_A, got);
        4: deselect();
        5: host_peek();
        default: begin
          SEL = 1'($urandom_range(0, 1)); TXE = 1'b0; RXE = 1'b0;
          step();
        end
      endcase
      TX_VALID = 1'b0;
    end
    deselect();

    // Reset pulsed during the second byte of a write.
    RX_READY = 1'b0;
    user_push(8'h3C);
    host_write(8'h01);
    SEL = 1'b1; ADDR = WR_A; RXD = 8'h02; RXE = 1'b1;
    #2 nRST = 1'b0;
    model_reset();
    @(negedge CLK);
    #1;
    chk1("mid_rst_rx_valid", RX_VALID, 1'b0);
    chk1("mid_rst_tx_ready", TX_READY, 1'b1);
    chk8("mid_rst_rx_data", RX_DATA, 8'h00);
    nRST = 1'b1;
    step();
    RXE = 1'b0; step();
    RXD = 8'h03; RXE = 1'b1; step();
    RXE = 1'b0; step();
    deselect();
    host_read(STAT_A, got); chk8("mid_rst_status", got, 8'h00);
    deselect();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
